// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - request/response bundle between the execute stage and div_ctrl
interface div_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_waddr_i;
  logic            flush_i;
  logic            busy_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_waddr_o;
  logic            rd_wen_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_waddr_i, flush_i,
    input  busy_o, ready_o, result_o, rd_waddr_o, rd_wen_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_waddr_i, flush_i,
    output busy_o, ready_o, result_o, rd_waddr_o, rd_wen_o
  );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - RV32M DIV/DIVU/REM/REMU restoring divider with writeback ownership
// Optional DIV_EARLY_OUT_EN: skip iteration when |divisor| > |dividend|.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  div_ctrl_if.slave   bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;
  state_t state, state_nxt;

  logic [1:0]      op_q;
  logic [XLEN-1:0] dvd_q, dvs_q, dvs_abs_q, rem_q, quot_q, result_q;
  logic [4:0]      rd_q, rd_out_q;
  logic [CW-1:0]   cnt_q;
  logic            q_neg_q, r_neg_q;

  logic            accept, is_signed, dvd_neg, dvs_neg, div_zero, early, last, ge;
  logic [XLEN-1:0] dvd_abs, dvs_abs, rem_step, quot_step, q_fix, r_fix;
  logic [XLEN:0]   rem_sh, diff;

  // Only the M-extension divide encodings (funct3[2]=1) start a request.
  assign accept    = bus.start_i & ~bus.flush_i & bus.op_i[2];
  assign is_signed = ~op_q[0];
  assign dvd_neg   = is_signed & dvd_q[XLEN-1];
  assign dvs_neg   = is_signed & dvs_q[XLEN-1];
  assign dvd_abs   = dvd_neg ? -dvd_q : dvd_q;
  assign dvs_abs   = dvs_neg ? -dvs_q : dvs_q;
  assign div_zero  = (dvs_q == '0);
`ifdef DIV_EARLY_OUT_EN
  assign early     = (dvs_abs > dvd_abs);
`else
  assign early     = 1'b0;
`endif

  // One restoring step; the shifted remainder may need XLEN+1 bits.
  assign rem_sh    = {rem_q, quot_q[XLEN-1]};
  assign diff      = rem_sh - {1'b0, dvs_abs_q};
  assign ge        = rem_sh[XLEN] | ~diff[XLEN];
  assign rem_step  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_step = {quot_q[XLEN-2:0], ge};
  assign q_fix     = q_neg_q ? -quot_step : quot_step;
  assign r_fix     = r_neg_q ? -rem_step : rem_step;
  assign last      = (cnt_q == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.busy_o   = 1'b0;
    bus.ready_o  = 1'b0;
    bus.rd_wen_o = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: begin
        bus.busy_o = 1'b1;
        if (bus.flush_i)            state_nxt = S_IDLE;
        else if (div_zero || early) state_nxt = S_END;
        else                        state_nxt = S_CALC;
      end
      S_CALC: begin
        bus.busy_o = 1'b1;
        if (bus.flush_i) state_nxt = S_IDLE;
        else if (last)   state_nxt = S_END;
      end
      S_END: begin
        bus.ready_o  = ~bus.flush_i;
        bus.rd_wen_o = ~bus.flush_i;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      dvs_abs_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q  <= bus.op_i[1:0];
          dvd_q <= bus.dividend_i;
          dvs_q <= bus.divisor_i;
          rd_q  <= bus.rd_waddr_i;
        end
        S_START: if (!bus.flush_i) begin
          dvs_abs_q <= dvs_abs;
          q_neg_q   <= dvd_neg ^ dvs_neg;
          r_neg_q   <= dvd_neg;
          cnt_q     <= '0;
          rem_q     <= '0;
          quot_q    <= dvd_abs;
          // Short paths: remainder is the untouched dividend in both cases.
          if (div_zero) begin
            result_q <= op_q[1] ? dvd_q : '1;
            rd_out_q <= rd_q;
          end else if (early) begin
            result_q <= op_q[1] ? dvd_q : '0;
            rd_out_q <= rd_q;
          end
        end
        S_CALC: if (!bus.flush_i) begin
          rem_q  <= rem_step;
          quot_q <= quot_step;
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            result_q <= op_q[1] ? r_fix : q_fix;
            rd_out_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o   = result_q;
  assign bus.rd_waddr_o = rd_out_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl
`timescale 1ns/1ps
module tb_div_ctrl;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if #(.XLEN(XLEN)) bus ();
  div_ctrl #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa, ba;
    aa = (!op[0] && a[31]) ? -a : a;
    ba = (!op[0] && b[31]) ? -b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ba > aa) return 2;
`endif
    return XLEN + 2;
  endfunction

  always @(negedge clk) begin
    if (!rst && (bus.ready_o || bus.rd_wen_o)) begin
      check("wen_eq_ready", {31'd0, bus.rd_wen_o}, {31'd0, bus.ready_o});
      if (sb_q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", bus.result_o, mon_e.result);
        check("rd_waddr", {27'd0, bus.rd_waddr_o}, {27'd0, mon_e.rd});
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit noise);
    int lat;
    bit seen;
    lat  = exp_lat(op, a, b);
    seen = 1'b0;
    sb_q.push_back({model(op, a, b), rd});
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_waddr_i = rd;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_c1", {31'd0, bus.busy_o}, 32'd1);
      if (c == lat - 1 && c > 1) check("busy_last", {31'd0, bus.busy_o}, 32'd1);
      if (bus.ready_o) begin
        check("latency", c, lat);
        check("busy_at_end", {31'd0, bus.busy_o}, 32'd0);
        seen = 1'b1;
        break;
      end
      if (noise) begin
        bus.start_i    = (c + 1 >= 3) && (c + 1 <= 20);
        bus.op_i       = 3'b100;
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
        bus.rd_waddr_i = 5'($urandom);
      end
    end
    if (!seen) check("timeout", 32'd0, 32'd1);
    bus.start_i = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {31'd0, bus.ready_o}, 32'd0);
    check("rd_hold", {27'd0, bus.rd_waddr_o}, {27'd0, rd});
    check("result_hold", bus.result_o, model(op, a, b));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i    = 1'b0;
    bus.op_i       = 3'b000;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.rd_waddr_i = '0;
    bus.flush_i    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    check("rst_wen", {31'd0, bus.rd_wen_o}, 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_rd", {27'd0, bus.rd_waddr_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(3'b101, 32'd100, 32'd7, 5'd5, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b0);
    run_op(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0);
    run_op(3'b100, 32'h1234_5678, 32'd0, 5'd4, 1'b0);
    run_op(3'b110, 32'h1234_5678, 32'd0, 5'd6, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);
    run_op(3'b101, 32'd3, 32'd10, 5'd10, 1'b0);
    run_op(3'b111, 32'd3, 32'd10, 5'd11, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 5'd12, 1'b1);

    // Flush in CALC: busy drops next cycle, no writeback ever appears.
    bus.start_i    = 1'b1;
    bus.op_i       = 3'b101;
    bus.dividend_i = 32'd100;
    bus.divisor_i  = 32'd7;
    bus.rd_waddr_i = 5'd13;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    check("busy_pre_flush", {31'd0, bus.busy_o}, 32'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("busy_post_flush", {31'd0, bus.busy_o}, 32'd0);
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    run_op(3'b101, 32'd9, 32'd3, 5'd14, 1'b0);

    // Flush during END suppresses the writeback strobe.
    bus.start_i    = 1'b1;
    bus.op_i       = 3'b100;
    bus.dividend_i = 32'd55;
    bus.divisor_i  = 32'd0;
    bus.rd_waddr_i = 5'd15;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    check("end_flush_ready", {31'd0, bus.ready_o}, 32'd0);
    check("end_flush_wen", {31'd0, bus.rd_wen_o}, 32'd0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op(3'(4 + (i % 4)), a, b, 5'($urandom), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divide controller and iterative restoring-divider datapath for RV32M DIV/DIVU/REM/REMU.
- Decode emits these ops with the GPR write suppressed, so this block owns the writeback.
- Accepts one request from the execute stage, holds the pipeline while iterating, then returns the result with a one-cycle writeback strobe.
- Services one request at a time.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN; counter width is $clog2(XLEN)+1.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
start_i  in  1  request strobe; sampled only in IDLE
op_i  in  3  funct3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU
dividend_i  in  XLEN  rs1 value
divisor_i  in  XLEN  rs2 value
rd_waddr_i  in  5  destination GPR address
flush_i  in  1  cancel request (jump/interrupt); abort in any state
busy_o  out  1  pipeline hold request
ready_o  out  1  result-valid strobe, one cycle
result_o  out  XLEN  quotient or remainder
rd_waddr_o  out  5  latched destination
rd_wen_o  out  1  GPR write enable; equals ready_o

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, all latches 0, busy_o=0, ready_o=0, rd_wen_o=0, result_o=0, rd_waddr_o=0.
- States:
  - IDLE: start_i=1 and flush_i=0 -> latch op, operands, rd; go to START. start_i with flush_i=1 is dropped.
  - START: compute magnitudes; signed ops take the two's-complement absolute value of negative operands; record result sign.
    - Divisor==0 -> END.
    - Otherwise -> CALC with counter=0, remainder=0, quotient register=|dividend|.
  - CALC: one restoring step per cycle.
    - Shift {rem,quot} left by 1.
    - Trial-subtract |divisor| from rem (XLEN+1-bit subtract). If non-negative, keep the difference and set the quotient LSB.
    - After XLEN steps -> END.
  - END: ready_o=1 and rd_wen_o=1 for exactly this cycle; result_o/rd_waddr_o valid. Next edge -> IDLE.
- busy_o=1 in START and CALC; 0 in IDLE and END. The pipeline is released in the same cycle the result is written.
- Latency: start_i high in cycle 0 -> START cycle 1, CALC cycles 2..XLEN+1, END cycle XLEN+2 (34 for XLEN=32).
  - Divide-by-zero: END in cycle 2.
- Sign fix-up on entry to END:
  - DIV quotient is negated if dividend sign != divisor sign.
  - REM remainder takes the dividend's sign.
  - Unsigned ops are not fixed up.
- Divide by zero: quotient=all ones, remainder=dividend (unmodified, all ops).
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. This falls out of the algorithm with no special case.
- Result selection: op_i[1]=0 selects quotient, op_i[1]=1 selects remainder.
- flush_i:
  - In START/CALC/END: next edge -> IDLE. No ready_o on following cycles; busy_o drops the cycle after.
  - If flush_i is high in END, ready_o/rd_wen_o are forced to 0 in that cycle.
- start_i outside IDLE is ignored (no queueing). A new start_i in the IDLE cycle after END is accepted normally.
- Latched operands are immune to input changes after acceptance.
- result_o and rd_waddr_o hold their last value outside END.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in START, if |divisor| > |dividend| (unsigned compare, divisor non-zero), skip CALC.
  - Quotient=0, remainder=dividend; go to END.
  - Total latency matches the divide-by-zero path (END in cycle 2).
- Undefined: every non-zero divisor takes the full XLEN CALC cycles; latency is fixed at XLEN+2.

Test Plan:
- DIVU 100/7, rd=5: start_i cycle 0 -> busy_o cycles 1-33; ready_o=1, rd_wen_o=1, result_o=14, rd_waddr_o=5 in cycle 34 only.
- REM -7 (0xFFFFFFF9) by 2 -> result_o=0xFFFFFFFF. DIV same operands -> 0xFFFFFFFD. REMU same operands -> 1.
- DIV x/0 with x=0x12345678 -> result_o=0xFFFFFFFF in cycle 2. REM x/0 -> 0x12345678. busy_o high only in cycle 1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- flush_i in cycle 10 of DIVU 100/7 -> busy_o=0 from cycle 11, no ready_o. Then a new DIVU 9/3 -> 3 at 34 cycles from its start. start_i pulses in cycles 3-20 of a running op are ignored.
- With DIV_EARLY_OUT_EN: DIVU 3/10 -> result_o=0 in cycle 2; REMU 3/10 -> 3. Without the macro: same values in cycle 34.
